rvvi_retire_arbiter: RTL and testbench
======================================

// Module: rvvi_retire_arbiter
// PURPOSE
//  Multi-hart retirement-record merger for the functional coverage bench. It accepts
//  per-hart retired-instruction records (order + packed RVVI payload), buffers each hart
//  in its own FIFO, and round-robin arbitrates them onto one valid/ready stream feeding
//  the coverage sampler. It also checks per-hart ORDER continuity and flags gaps.
// PARAMETERS
//  NHART    2   number of hart input channels (1..16)
//  DEPTH    4   entries per hart FIFO (power of 2, >=2)
//  REC_W    128 packed record width (insn, pc, trap, mode, ...), opaque to this block
//  ORDER_W  64  width of the retirement order field
// PORTS
//  clk        in   1               clock, all state on posedge
//  reset_n    in   1               asynchronous active-low reset
//  flush      in   1               sync clear of all FIFOs and the RR pointer
//  in_valid   in   NHART           per-hart record valid
//  in_ready   out  NHART           per-hart FIFO not full
//  in_order   in   NHART*ORDER_W   per-hart order value, hart h at [h*ORDER_W +: ORDER_W]
//  in_rec     in   NHART*REC_W     per-hart record payload, same slicing
//  out_valid  out  1               merged record valid
//  out_ready  in   1               sampler accepts the record
//  out_hart   out  $clog2(NHART)   source hart of out_rec (1 bit when NHART==1)
//  out_order  out  ORDER_W         order of out_rec
//  out_rec    out  REC_W           merged record payload
//  order_err  out  NHART           sticky per-hart order-gap flag
//  overflow   out  NHART           sticky: in_valid seen while in_ready low
// BEHAVIOUR
//  Reset (async, reset_n=0): FIFOs empty, rr_ptr=0, grant lock cleared, expected_order[h]=0,
//   order_err=0, overflow=0. Therefore out_valid=0, in_ready=all 1, and out_* data=0.
//  Push: hart h accepts when in_valid[h] & in_ready[h]. in_ready[h]=!full[h] depends on state
//   only, never on in_valid or out_ready. A full FIFO never accepts a push, even in a cycle
//   where it pops.
//  Latency: a record pushed at edge N can appear on out_* after edge N (1 cycle). No bypass.
//  Arbitration: out_valid=|nonempty. Grant is the first non-empty hart, searching from rr_ptr
//   upward with wrap. On a pop (out_valid & out_ready), rr_ptr <= grant+1 mod NHART.
//  Stall stability: while out_valid & !out_ready, the grant is locked (registered). out_hart,
//   out_order and out_rec hold stable until the pop, even if a higher-priority hart fills.
//  Simultaneous push/pop on the same hart: both occur and the occupancy is unchanged.
//   Push into empty + pop of another hart: independent.
//  Order check, on each accepted push for hart h:
//   - if in_order != expected_order[h], set order_err[h] (sticky);
//   - expected_order[h] <= in_order+1 (resync), wrapping mod 2^ORDER_W.
//   The first record after reset must have order 0.
//  Overflow: in_valid[h] & !in_ready[h] sets overflow[h] (sticky). The record is not taken.
//  flush=1: all FIFOs are emptied, rr_ptr=0, grant lock cleared, and no push or pop takes
//   effect that cycle. expected_order, order_err and overflow are preserved. Only reset
//   clears the sticky flags.
//  Reset mid-transfer: all in-flight records are discarded and nothing is emitted
//   after release.
//  FIFO pointers use log2(DEPTH)+1 bits, with the wrap bit distinguishing full from empty.
// TESTING
//  1. Reset, hart0 pushes order 0,1,2 back-to-back, out_ready=1 -> out_order 0,1,2 on
//     consecutive cycles, out_hart=0, order_err=0.
//  2. NHART=2: both harts hold 3 records, out_ready=1 -> out_hart sequence 0,1,0,1,0,1.
//  3. Hold out_ready=0 with hart1 granted, then fill hart0 -> out_hart/out_rec stable
//     until out_ready=1, then hart1 pops first.
//  4. Fill hart0 with DEPTH=4 records, keep in_valid high -> in_ready[0]=0 on the 5th
//     cycle, overflow[0]=1, and 4 records drain in order.
//  5. Hart1 pushes order 0,1,3,4 -> order_err[1] set when 3 is accepted; no error on 4.
//  6. ORDER_W=4: push orders 14,15,0 (error on 14 expected from reset) -> no new error at
//     the wrap. Then flush with 2 queued -> out_valid=0 the next cycle, and flags held.

Source files
------------

// File: rtl/rvvi_retire_arbiter_if.sv
// Record streams for the retirement arbiter: per-hart inputs, merged output and
// sticky status. The arbiter sits on the slave side.
interface rvvi_retire_arbiter_if #(
    parameter int unsigned NHART   = 2,
    parameter int unsigned REC_W   = 128,
    parameter int unsigned ORDER_W = 64
);
    localparam int unsigned HART_W = (NHART > 1) ? $clog2(NHART) : 1;

    logic [NHART-1:0]         in_valid;
    logic [NHART-1:0]         in_ready;
    logic [NHART*ORDER_W-1:0] in_order;
    logic [NHART*REC_W-1:0]   in_rec;
    logic                     out_valid;
    logic                     out_ready;
    logic [HART_W-1:0]        out_hart;
    logic [ORDER_W-1:0]       out_order;
    logic [REC_W-1:0]         out_rec;
    logic [NHART-1:0]         order_err;
    logic [NHART-1:0]         overflow;

    modport master (
        output in_valid, in_order, in_rec, out_ready,
        input  in_ready, out_valid, out_hart, out_order, out_rec, order_err, overflow
    );

    modport slave (
        input  in_valid, in_order, in_rec, out_ready,
        output in_ready, out_valid, out_hart, out_order, out_rec, order_err, overflow
    );
endinterface

// File: rtl/rvvi_retire_arbiter.sv
// Per-hart retirement FIFOs merged round-robin onto one stream, with sticky
// per-hart order-gap and overflow flags.
module rvvi_retire_arbiter #(
    parameter int unsigned NHART   = 2,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned REC_W   = 128,
    parameter int unsigned ORDER_W = 64
) (
    input logic                  clk,
    input logic                  reset_n,
    input logic                  flush,
    rvvi_retire_arbiter_if.slave bus
);
    localparam int unsigned HART_W = (NHART > 1) ? $clog2(NHART) : 1;
    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned ENT_W  = ORDER_W + REC_W;

    logic [ENT_W-1:0]   mem_q       [NHART][DEPTH];
    logic [AW:0]        wr_ptr_q    [NHART];
    logic [AW:0]        rd_ptr_q    [NHART];
    logic [ORDER_W-1:0] exp_order_q [NHART];
    logic [NHART-1:0]   order_err_q, overflow_q;
    logic [HART_W-1:0]  rr_ptr_q, rr_ptr_d, lock_hart_q, lock_hart_d, grant;
    logic               lock_q, lock_d, fire;
    logic [NHART-1:0]   nonempty, full, push, pop;

    always_comb begin
        for (int unsigned h = 0; h < NHART; h++) begin
            nonempty[h] = wr_ptr_q[h] != rd_ptr_q[h];
            full[h]     = (wr_ptr_q[h][AW] != rd_ptr_q[h][AW]) &&
                          (wr_ptr_q[h][AW-1:0] == rd_ptr_q[h][AW-1:0]);
        end
        bus.out_valid = |nonempty;
        bus.in_ready  = ~full;
        bus.order_err = order_err_q;
        bus.overflow  = overflow_q;
    end

    // A stalled grant stays registered so the presented record cannot change under the sampler.
    always_comb begin
        int unsigned idx;
        logic        found;
        idx   = 0;
        found = 1'b0;
        grant = lock_hart_q;
        if (!lock_q) begin
            grant = '0;
            for (int unsigned i = 0; i < NHART; i++) begin
                idx = 32'(rr_ptr_q) + i;
                if (idx >= NHART) idx = idx - NHART;
                for (int unsigned h = 0; h < NHART; h++) begin
                    if (!found && nonempty[h] && idx == h) begin
                        grant = HART_W'(h);
                        found = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        fire        = bus.out_valid & bus.out_ready & ~flush;
        rr_ptr_d    = rr_ptr_q;
        lock_d      = lock_q;
        lock_hart_d = lock_hart_q;
        if (flush) begin
            rr_ptr_d = '0;
            lock_d   = 1'b0;
        end else if (fire) begin
            lock_d = 1'b0;
            if (32'(grant) + 32'd1 >= NHART) rr_ptr_d = '0;
            else                             rr_ptr_d = grant + 1'b1;
        end else if (bus.out_valid) begin
            lock_d      = 1'b1;
            lock_hart_d = grant;
        end
        for (int unsigned h = 0; h < NHART; h++) begin
            push[h] = bus.in_valid[h] & ~full[h] & ~flush;
            pop[h]  = fire & (grant == HART_W'(h));
        end
    end

    always_comb begin
        bus.out_hart  = grant;
        bus.out_order = '0;
        bus.out_rec   = '0;
        for (int unsigned h = 0; h < NHART; h++) begin
            if (bus.out_valid && grant == HART_W'(h)) begin
                {bus.out_order, bus.out_rec} = mem_q[h][rd_ptr_q[h][AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned h = 0; h < NHART; h++) begin
            if (push[h]) begin
                mem_q[h][wr_ptr_q[h][AW-1:0]] <= {bus.in_order[h*ORDER_W +: ORDER_W],
                                                  bus.in_rec[h*REC_W +: REC_W]};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned h = 0; h < NHART; h++) begin
                wr_ptr_q[h]    <= '0;
                rd_ptr_q[h]    <= '0;
                exp_order_q[h] <= '0;
            end
            order_err_q <= '0;
            overflow_q  <= '0;
            rr_ptr_q    <= '0;
            lock_q      <= 1'b0;
            lock_hart_q <= '0;
        end else begin
            overflow_q  <= overflow_q | (bus.in_valid & full);
            rr_ptr_q    <= rr_ptr_d;
            lock_q      <= lock_d;
            lock_hart_q <= lock_hart_d;
            for (int unsigned h = 0; h < NHART; h++) begin
                if (push[h]) begin
                    wr_ptr_q[h]    <= wr_ptr_q[h] + 1'b1;
                    // Resync on every push so one gap reports once, not on every later record.
                    exp_order_q[h] <= bus.in_order[h*ORDER_W +: ORDER_W] + 1'b1;
                    if (bus.in_order[h*ORDER_W +: ORDER_W] != exp_order_q[h]) begin
                        order_err_q[h] <= 1'b1;
                    end
                end
                if (pop[h]) rd_ptr_q[h] <= rd_ptr_q[h] + 1'b1;
                if (flush) begin
                    wr_ptr_q[h] <= '0;
                    rd_ptr_q[h] <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_rvvi_retire_arbiter.sv
// Directed bench for rvvi_retire_arbiter: per-hart scoreboards check every popped
// record; a second instance with a 4-bit order field covers wrap and flush.
module tb_rvvi_retire_arbiter;
    localparam int unsigned NH  = 2;
    localparam int unsigned DP  = 4;
    localparam int unsigned RW  = 128;
    localparam int unsigned OW  = 64;
    localparam int unsigned OWB = 4;

    logic clk = 1'b0;
    logic reset_n;
    logic flush_a;
    logic flush_b;

    always #5 clk = ~clk;

    rvvi_retire_arbiter_if #(.NHART(NH), .REC_W(RW), .ORDER_W(OW))  bus_a ();
    rvvi_retire_arbiter_if #(.NHART(NH), .REC_W(RW), .ORDER_W(OWB)) bus_b ();

    rvvi_retire_arbiter #(.NHART(NH), .DEPTH(DP), .REC_W(RW), .ORDER_W(OW)) u_dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush_a),
        .bus     (bus_a)
    );

    rvvi_retire_arbiter #(.NHART(NH), .DEPTH(DP), .REC_W(RW), .ORDER_W(OWB)) u_dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush_b),
        .bus     (bus_b)
    );

    int checks = 0;
    int errors = 0;
    logic [OW+RW-1:0] sb0[$];
    logic [OW+RW-1:0] sb1[$];
    logic [RW-1:0]    last_rec;
    logic [RW-1:0]    hold_rec;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_pop();
        logic [OW+RW-1:0] exp;
        if (bus_a.out_hart == 1'b0 && sb0.size() != 0) begin
            exp = sb0.pop_front();
            chk("pop_data_h0", 256'({bus_a.out_order, bus_a.out_rec}), 256'(exp));
        end else if (bus_a.out_hart == 1'b1 && sb1.size() != 0) begin
            exp = sb1.pop_front();
            chk("pop_data_h1", 256'({bus_a.out_order, bus_a.out_rec}), 256'(exp));
        end else begin
            chk("pop_unexpected", 256'(bus_a.out_valid), 256'(0));
        end
    endtask

    task automatic tick();
        if (bus_a.out_valid && bus_a.out_ready) check_pop();
        @(posedge clk);
        #1;
        bus_a.in_valid = '0;
        bus_b.in_valid = '0;
    endtask

    task automatic drive_a(input int h, input logic [OW-1:0] ord, input bit take);
        logic [RW-1:0] rec;
        rec = {$urandom, $urandom, $urandom, $urandom};
        bus_a.in_valid[h]          = 1'b1;
        bus_a.in_order[h*OW +: OW] = ord;
        bus_a.in_rec[h*RW +: RW]   = rec;
        last_rec = rec;
        if (take) begin
            if (h == 0) sb0.push_back({ord, rec});
            else        sb1.push_back({ord, rec});
        end
    endtask

    task automatic drive_b(input int h, input logic [OWB-1:0] ord);
        bus_b.in_valid[h]            = 1'b1;
        bus_b.in_order[h*OWB +: OWB] = ord;
        bus_b.in_rec[h*RW +: RW]     = {96'd0, $urandom};
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        sb0.delete();
        sb1.delete();
    endtask

    initial begin
        reset_n = 1'b0;
        flush_a = 1'b0;
        flush_b = 1'b0;
        bus_a.in_valid = '0; bus_a.in_order = '0; bus_a.in_rec = '0; bus_a.out_ready = 1'b0;
        bus_b.in_valid = '0; bus_b.in_order = '0; bus_b.in_rec = '0; bus_b.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 256'(bus_a.out_valid), 256'(0));
        chk("rst_ready", 256'(bus_a.in_ready), 256'(2'b11));
        chk("rst_hart", 256'(bus_a.out_hart), 256'(0));
        chk("rst_order", 256'(bus_a.out_order), 256'(0));
        chk("rst_rec", 256'(bus_a.out_rec), 256'(0));
        chk("rst_err", 256'(bus_a.order_err), 256'(0));
        chk("rst_ovf", 256'(bus_a.overflow), 256'(0));
        reset_n = 1'b1;
        tick();

        // Back-to-back single-hart stream.
        bus_a.out_ready = 1'b1;
        drive_a(0, OW'(0), 1'b1); tick();
        chk("t1_valid", 256'(bus_a.out_valid), 256'(1));
        chk("t1_hart", 256'(bus_a.out_hart), 256'(0));
        chk("t1_ord0", 256'(bus_a.out_order), 256'(0));
        drive_a(0, OW'(1), 1'b1); tick();
        chk("t1_ord1", 256'(bus_a.out_order), 256'(1));
        drive_a(0, OW'(2), 1'b1); tick();
        chk("t1_ord2", 256'(bus_a.out_order), 256'(2));
        tick();
        chk("t1_empty", 256'(bus_a.out_valid), 256'(0));
        chk("t1_err", 256'(bus_a.order_err), 256'(0));

        // Round-robin alternation from a fresh reset.
        apply_reset();
        bus_a.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_a(0, OW'(k), 1'b1);
            drive_a(1, OW'(k), 1'b1);
            tick();
        end
        bus_a.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            chk("t2_hart_seq", 256'(bus_a.out_hart), 256'(k % 2));
            tick();
        end
        chk("t2_empty", 256'(bus_a.out_valid), 256'(0));

        // Stalled grant on hart1 must survive hart0 filling.
        bus_a.out_ready = 1'b0;
        drive_a(1, OW'(3), 1'b1); hold_rec = last_rec; tick();
        chk("t3_hart", 256'(bus_a.out_hart), 256'(1));
        for (int k = 0; k < 2; k++) begin
            drive_a(0, OW'(3 + k), 1'b1); tick();
            chk("t3_hold_hart", 256'(bus_a.out_hart), 256'(1));
            chk("t3_hold_rec", 256'(bus_a.out_rec), 256'(hold_rec));
        end
        bus_a.out_ready = 1'b1;
        chk("t3_first", 256'(bus_a.out_hart), 256'(1));
        tick();
        chk("t3_next", 256'(bus_a.out_hart), 256'(0));
        tick(); tick();
        chk("t3_empty", 256'(bus_a.out_valid), 256'(0));

        // Fill hart0 to DEPTH and keep pushing.
        bus_a.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("t4_ready", 256'(bus_a.in_ready[0]), 256'(k < 4));
            drive_a(0, OW'(5 + k), k < 4); tick();
        end
        chk("t4_ovf", 256'(bus_a.overflow), 256'(2'b01));
        chk("t4_full", 256'(bus_a.in_ready), 256'(2'b10));
        bus_a.out_ready = 1'b1;
        repeat (4) tick();
        chk("t4_empty", 256'(bus_a.out_valid), 256'(0));
        chk("t4_err", 256'(bus_a.order_err), 256'(0));

        // Order gap on hart1 (expected order continues from 4).
        drive_a(1, OW'(4), 1'b1); tick();
        drive_a(1, OW'(5), 1'b1); tick();
        chk("t5_noerr", 256'(bus_a.order_err), 256'(0));
        drive_a(1, OW'(7), 1'b1); tick();
        chk("t5_err", 256'(bus_a.order_err), 256'(2'b10));
        drive_a(1, OW'(8), 1'b1); tick();
        tick();
        chk("t5_err_hold", 256'(bus_a.order_err), 256'(2'b10));
        chk("t5_empty", 256'(bus_a.out_valid), 256'(0));

        // 4-bit order field: wrap, flush with two queued.
        bus_b.out_ready = 1'b0;
        drive_b(0, 4'd14); tick();
        chk("t6_err14", 256'(bus_b.order_err), 256'(2'b01));
        drive_b(0, 4'd15); tick();
        drive_b(0, 4'd0);  tick();
        chk("t6_wrap", 256'(bus_b.order_err), 256'(2'b01));
        bus_b.out_ready = 1'b1; tick(); bus_b.out_ready = 1'b0;
        chk("t6_queued", 256'(bus_b.out_valid), 256'(1));
        flush_b = 1'b1;
        drive_b(1, 4'd0); tick();
        flush_b = 1'b0;
        chk("t6_flush_valid", 256'(bus_b.out_valid), 256'(0));
        chk("t6_flush_ready", 256'(bus_b.in_ready), 256'(2'b11));
        chk("t6_flush_err", 256'(bus_b.order_err), 256'(2'b01));
        chk("t6_flush_ovf", 256'(bus_b.overflow), 256'(0));
        bus_b.out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive_b(1, OWB'(i)); tick();
            if (i == 0) begin
                chk("t6_h1_hart", 256'(bus_b.out_hart), 256'(1));
                chk("t6_h1_order", 256'(bus_b.out_order), 256'(0));
            end
        end
        chk("t6_h1_wrap", 256'(bus_b.order_err), 256'(2'b01));

        // Reset with records in flight.
        bus_a.out_ready = 1'b0;
        drive_a(0, OW'(9), 1'b0); tick();
        drive_a(0, OW'(10), 1'b0); tick();
        chk("t7_busy", 256'(bus_a.out_valid), 256'(1));
        apply_reset();
        chk("t7_cleared", 256'(bus_a.out_valid), 256'(0));
        bus_a.out_ready = 1'b1;
        tick(); tick();
        chk("t7_quiet", 256'(bus_a.out_valid), 256'(0));
        chk("t7_flags", 256'({bus_a.order_err, bus_a.overflow}), 256'(0));

        chk("sb0_left", 256'(sb0.size()), 256'(0));
        chk("sb1_left", 256'(sb1.size()), 256'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
